// File: rtl/fan_pkg.sv
// fan_pkg: shared definitions for the multi-channel fan controller.
//   fan_cfg_t    : bundle of default configuration values
//   PWM_MAX      : largest duty code at the default PWM resolution
//   MEAS_MAX     : largest revolution time (us) at the default measurement width
//   duty_slice() : extracts one channel's duty field from the packed request bus
package fan_pkg;

    typedef struct packed {
        int unsigned n_fan;
        int unsigned pwm_bits;
        int unsigned pwm_div;
        int unsigned meas_bits;
        int unsigned ppr;
        int unsigned kick_ms;
    } fan_cfg_t;

    localparam fan_cfg_t FAN_CFG_DEF = '{
        n_fan:     32'd2,
        pwm_bits:  32'd8,
        pwm_div:   32'd32,
        meas_bits: 32'd20,
        ppr:       32'd2,
        kick_ms:   32'd500
    };

    localparam int unsigned PWM_MAX  = (32'd1 << FAN_CFG_DEF.pwm_bits) - 32'd1;
    localparam int unsigned MEAS_MAX = (32'd1 << FAN_CFG_DEF.meas_bits) - 32'd1;

    // Widest duty field and widest packed request bus the helper supports.
    localparam int unsigned DUTY_W_MAX = 32'd16;
    localparam int unsigned PCT_W_MAX  = 32'd256;

    // Returns channel ch's duty field (bits wide), zero-extended to DUTY_W_MAX.
    function automatic logic [DUTY_W_MAX-1:0] duty_slice(
        input logic [PCT_W_MAX-1:0] pct_vec,
        input int unsigned          ch,
        input int unsigned          bits
    );
        logic [PCT_W_MAX-1:0]  shifted;
        logic [DUTY_W_MAX-1:0] mask;
        shifted = pct_vec >> (ch * bits);
        mask    = DUTY_W_MAX'((32'd1 << bits) - 32'd1);
        return shifted[DUTY_W_MAX-1:0] & mask;
    endfunction

endpackage

// File: rtl/fan_tach_meas.sv
// fan_tach_meas: per-channel tach front end and revolution-time measurement.
//   clk, rst_n : system clock, asynchronous active-low reset
//   us_stb     : 1-cycle strobe every microsecond
//   tach_in    : raw asynchronous tach input
//   force_off  : fan commanded off; suppresses the stall flag
//   uspr       : microseconds per full revolution (PPR tach pulses)
//   stall      : no completed revolution before the accumulator saturated
module fan_tach_meas
    import fan_pkg::*;
#(
    parameter int unsigned MEAS_BITS = FAN_CFG_DEF.meas_bits,
    parameter int unsigned PPR       = FAN_CFG_DEF.ppr
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 us_stb,
    input  logic                 tach_in,
    input  logic                 force_off,
    output logic [MEAS_BITS-1:0] uspr,
    output logic                 stall
);

    localparam int unsigned          PC_W    = (PPR > 1) ? $clog2(PPR) : 1;
    localparam logic [PC_W-1:0]      PC_LAST = PC_W'(PPR - 1);
    localparam logic [PC_W-1:0]      PC_ZERO = {PC_W{1'b0}};
    localparam logic [MEAS_BITS-1:0] ACC_MAX = {MEAS_BITS{1'b1}};
    localparam logic [MEAS_BITS-1:0] ACC_ONE = MEAS_BITS'(1'b1);

    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic                 samp_q, samp_d;
    logic                 prev_q, prev_d;
    logic [MEAS_BITS-1:0] acc_q, acc_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    // armed_q: a revolution start edge has been seen since reset or stall, so
    // acc is counting from a real edge and the next completion is trustworthy.
    // This is why the first valid result after reset needs PPR+1 edges.
    logic                 armed_q, armed_d;
    logic [MEAS_BITS-1:0] uspr_q, uspr_d;
    logic                 stall_q, stall_d;
    logic                 rise_s;
    logic                 acc_at_max_s;
    logic [MEAS_BITS-1:0] acc_inc_s;

    // Synchroniser, us-rate sampling, edge detection and measurement next state
    always_comb begin
        sync1_d      = tach_in;
        sync2_d      = sync1_q;
        samp_d       = samp_q;
        prev_d       = prev_q;
        acc_d        = acc_q;
        pc_d         = pc_q;
        armed_d      = armed_q;
        uspr_d       = uspr_q;
        stall_d      = stall_q;
        rise_s       = samp_q & ~prev_q;
        acc_at_max_s = (acc_q == ACC_MAX);
        acc_inc_s    = acc_at_max_s ? ACC_MAX : (acc_q + ACC_ONE);

        if (us_stb) begin
            samp_d = sync2_q;
            prev_d = samp_q;
            if (rise_s) begin
                // An edge takes priority over saturation on the same strobe.
                if (!armed_q) begin
                    acc_d   = ACC_ONE;
                    pc_d    = PC_ZERO;
                    armed_d = 1'b1;
                end else if (pc_q == PC_LAST) begin
                    uspr_d  = acc_q;
                    acc_d   = ACC_ONE;
                    pc_d    = PC_ZERO;
                    stall_d = 1'b0;
                end else begin
                    pc_d  = pc_q + PC_W'(1'b1);
                    acc_d = acc_inc_s;
                end
            end else if (acc_at_max_s) begin
                // The revolution in progress is lost; restart from the next edge.
                uspr_d  = ACC_MAX;
                stall_d = 1'b1;
                armed_d = 1'b0;
            end else begin
                acc_d = acc_inc_s;
            end
        end else begin
            acc_d = acc_q;
        end

        if (force_off) begin
            stall_d = 1'b0;
        end else begin
            stall_d = stall_d;
        end
    end

    // Measurement state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            samp_q  <= 1'b0;
            prev_q  <= 1'b0;
            acc_q   <= {MEAS_BITS{1'b0}};
            pc_q    <= PC_ZERO;
            armed_q <= 1'b0;
            uspr_q  <= {MEAS_BITS{1'b0}};
            stall_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            samp_q  <= samp_d;
            prev_q  <= prev_d;
            acc_q   <= acc_d;
            pc_q    <= pc_d;
            armed_q <= armed_d;
            uspr_q  <= uspr_d;
            stall_q <= stall_d;
        end
    end

    assign uspr  = uspr_q;
    assign stall = stall_q;

endmodule

// File: rtl/fan_ctrl_multi.sv
// fan_ctrl_multi: multi-channel fan controller.
//   clk, rst_n : system clock, asynchronous active-low reset
//   tsc_1ppms  : 1-cycle strobe every millisecond (kick timing)
//   tsc_1ppus  : 1-cycle strobe every microsecond (tach measurement)
//   fan_pct    : requested duty, channel i at [i*PWM_BITS +: PWM_BITS]
//   fan_tach   : raw asynchronous tach inputs
//   fan_pwm    : registered PWM outputs, all channels phase-aligned
//   fan_uspr   : microseconds per revolution, channel i at [i*MEAS_BITS +: MEAS_BITS]
//   fan_stall  : stall flag per channel
module fan_ctrl_multi
    import fan_pkg::*;
#(
    parameter int unsigned N_FAN     = FAN_CFG_DEF.n_fan,
    parameter int unsigned PWM_BITS  = FAN_CFG_DEF.pwm_bits,
    parameter int unsigned PWM_DIV   = FAN_CFG_DEF.pwm_div,
    parameter int unsigned MEAS_BITS = FAN_CFG_DEF.meas_bits,
    parameter int unsigned PPR       = FAN_CFG_DEF.ppr,
    parameter int unsigned KICK_MS   = FAN_CFG_DEF.kick_ms
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         tsc_1ppms,
    input  logic                         tsc_1ppus,
    input  logic [N_FAN*PWM_BITS-1:0]    fan_pct,
    input  logic [N_FAN-1:0]             fan_tach,
    output logic [N_FAN-1:0]             fan_pwm,
    output logic [N_FAN*MEAS_BITS-1:0]   fan_uspr,
    output logic [N_FAN-1:0]             fan_stall
);

    localparam int unsigned         PRESC_W    = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int unsigned         KICK_W     = (KICK_MS > 0) ? $clog2(KICK_MS + 1) : 1;
    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(PWM_DIV - 1);
    localparam logic [PWM_BITS-1:0] DUTY_FULL  = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] DUTY_ZERO  = {PWM_BITS{1'b0}};
    localparam logic [KICK_W-1:0]   KICK_LOAD  = KICK_W'(KICK_MS);
    localparam logic [KICK_W-1:0]   KICK_ZERO  = {KICK_W{1'b0}};

    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [PWM_BITS-1:0]  cnt_q, cnt_d;
    logic                 pwm_ce_s;
    logic                 period_start_s;
    logic [PCT_W_MAX-1:0] pct_pad_s;

    // Prescaler and shared period counter next state
    always_comb begin
        pwm_ce_s       = (presc_q == PRESC_LAST);
        period_start_s = pwm_ce_s && (cnt_q == DUTY_FULL);
        if (pwm_ce_s) begin
            presc_d = {PRESC_W{1'b0}};
            cnt_d   = cnt_q + PWM_BITS'(1'b1);
        end else begin
            presc_d = presc_q + PRESC_W'(1'b1);
            cnt_d   = cnt_q;
        end
    end

    // Prescaler and period counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= {PRESC_W{1'b0}};
            cnt_q   <= DUTY_ZERO;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pct_pad_s = PCT_W_MAX'(fan_pct);

    for (genvar i = 0; i < N_FAN; i++) begin : g_ch
        logic [PWM_BITS-1:0] pct_s;
        logic [PWM_BITS-1:0] duty_q, duty_d;
        logic [KICK_W-1:0]   kick_q, kick_d;
        logic [PWM_BITS-1:0] duty_eff_s;
        logic                pwm_q, pwm_d;
        logic                off_s;

        // Duty latch at period start, kick load/countdown, PWM compare
        always_comb begin
            pct_s  = PWM_BITS'(duty_slice(pct_pad_s, 32'(i), PWM_BITS));
            duty_d = duty_q;
            kick_d = kick_q;
            if (period_start_s) begin
                duty_d = pct_s;
                if (pct_s == DUTY_ZERO) begin
                    kick_d = KICK_ZERO;
                end else if ((duty_q == DUTY_ZERO) && (KICK_MS > 0)) begin
                    kick_d = KICK_LOAD;
                end else if (tsc_1ppms && (kick_q != KICK_ZERO)) begin
                    kick_d = kick_q - KICK_W'(1'b1);
                end else begin
                    kick_d = kick_q;
                end
            end else if (tsc_1ppms && (kick_q != KICK_ZERO)) begin
                kick_d = kick_q - KICK_W'(1'b1);
            end else begin
                kick_d = kick_q;
            end

            duty_eff_s = (kick_q != KICK_ZERO) ? DUTY_FULL : duty_q;
            // Full-scale duty must stay high through the last count too.
            pwm_d      = (duty_eff_s == DUTY_FULL) || (cnt_q < duty_eff_s);
            off_s      = (duty_eff_s == DUTY_ZERO);
        end

        // Per-channel duty, kick and PWM output registers
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                duty_q <= DUTY_ZERO;
                kick_q <= KICK_ZERO;
                pwm_q  <= 1'b0;
            end else begin
                duty_q <= duty_d;
                kick_q <= kick_d;
                pwm_q  <= pwm_d;
            end
        end

        assign fan_pwm[i] = pwm_q;

        fan_tach_meas #(
            .MEAS_BITS (MEAS_BITS),
            .PPR       (PPR)
        ) u_meas (
            .clk       (clk),
            .rst_n     (rst_n),
            .us_stb    (tsc_1ppus),
            .tach_in   (fan_tach[i]),
            .force_off (off_s),
            .uspr      (fan_uspr[i*MEAS_BITS +: MEAS_BITS]),
            .stall     (fan_stall[i])
        );
    end

endmodule

// File: tb/tb_fan_ctrl_multi.sv
// tb_fan_ctrl_multi: directed self-checking bench for fan_ctrl_multi.
// Scaled configuration: PWM period 512 clk, 1 us = 4 clk, 1 ms = 400 clk,
// 10-bit measurement (saturates at 1023 us), PPR 2, 3 ms kick.
module tb_fan_ctrl_multi;

    localparam int NF = 2;
    localparam int PB = 8;
    localparam int PD = 2;
    localparam int MB = 10;
    localparam int PR = 2;
    localparam int KM = 3;

    logic                 clk;
    logic                 rst_n;
    logic                 tsc_1ppms;
    logic                 tsc_1ppus;
    logic [NF*PB-1:0]     fan_pct;
    logic [NF-1:0]        fan_tach;
    logic [NF-1:0]        fan_pwm;
    logic [NF*MB-1:0]     fan_uspr;
    logic [NF-1:0]        fan_stall;

    int vectors;
    int miscompares;
    int hi;
    int hi2;

    fan_ctrl_multi #(
        .N_FAN     (NF),
        .PWM_BITS  (PB),
        .PWM_DIV   (PD),
        .MEAS_BITS (MB),
        .PPR       (PR),
        .KICK_MS   (KM)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tsc_1ppms (tsc_1ppms),
        .tsc_1ppus (tsc_1ppus),
        .fan_pct   (fan_pct),
        .fan_tach  (fan_tach),
        .fan_pwm   (fan_pwm),
        .fan_uspr  (fan_uspr),
        .fan_stall (fan_stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running time-base strobes, changed on the falling edge.
    initial begin
        int us_div;
        int ms_div;
        us_div    = 0;
        ms_div    = 0;
        tsc_1ppus = 1'b0;
        tsc_1ppms = 1'b0;
        forever begin
            @(negedge clk);
            us_div    = (us_div == 3) ? 0 : us_div + 1;
            ms_div    = (ms_div == 399) ? 0 : ms_div + 1;
            tsc_1ppus = (us_div == 3);
            tsc_1ppms = (ms_div == 399);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_pct(input int ch, input logic [PB-1:0] val);
        fan_pct[ch*PB +: PB] = val;
    endtask

    // Counts high samples over n falling edges starting with the current one.
    task automatic count_high(input int ch, input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            if (fan_pwm[ch]) cnt++;
            @(negedge clk);
        end
    endtask

    // Waits (bounded) for a rising edge of fan_pwm[ch]; returns on the first high sample.
    task automatic wait_rise(input int ch);
        logic prev;
        bit   found;
        prev  = fan_pwm[ch];
        found = 1'b0;
        for (int k = 0; k < 2000 && !found; k++) begin
            @(negedge clk);
            if (!prev && fan_pwm[ch]) found = 1'b1;
            prev = fan_pwm[ch];
        end
        check("pwm_rise_seen", {31'd0, found}, 32'd1);
    endtask

    // One tach period of `us` microseconds: high for half, low for half.
    task automatic tach_cycle(input int ch, input int us);
        fan_tach[ch] = 1'b1;
        repeat (us * 2) @(negedge clk);
        fan_tach[ch] = 1'b0;
        repeat (us * 2) @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        fan_pct     = '0;
        fan_tach    = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_pwm",   32'(fan_pwm),   32'd0);
        check("rst_uspr",  32'(fan_uspr),  32'd0);
        check("rst_stall", 32'(fan_stall), 32'd0);
        rst_n = 1'b1;

        // Basic duty: ch0 0x40 -> 128 of 512 clk, ch1 0xFF -> constant high
        set_pct(0, 8'h40);
        set_pct(1, 8'hFF);
        repeat (2000) @(negedge clk);
        count_high(0, 512, hi);
        check("duty_40", hi, 32'd128);
        count_high(1, 512, hi);
        check("duty_ff", hi, 32'd512);

        // Mid-period change 0x40 -> 0x80: current period unchanged, next period new duty
        wait_rise(0);
        count_high(0, 100, hi);
        set_pct(0, 8'h80);
        count_high(0, 412, hi2);
        check("midper_keep", hi + hi2, 32'd128);
        count_high(0, 512, hi);
        check("midper_next", hi, 32'd256);

        // Mid-period change to 0: current period full, then constant low
        wait_rise(0);
        count_high(0, 100, hi);
        set_pct(0, 8'h00);
        count_high(0, 412, hi2);
        check("off_keep", hi + hi2, 32'd256);
        count_high(0, 512, hi);
        check("off_low", hi, 32'd0);

        // Kick: 0 -> 0x20 gives ~3 ms (>800 clk) constant high, then 64 of 512
        set_pct(0, 8'h20);
        wait_rise(0);
        count_high(0, 780, hi);
        check("kick_high", hi, 32'd780);
        count_high(0, 520, hi);
        count_high(0, 512, hi);
        check("kick_after", hi, 32'd64);

        // Kick cancelled by latching 0 during the kick
        set_pct(0, 8'h00);
        repeat (600) @(negedge clk);
        set_pct(0, 8'h20);
        wait_rise(0);
        count_high(0, 20, hi);
        set_pct(0, 8'h00);
        count_high(0, 500, hi);
        count_high(0, 512, hi);
        check("kick_cancel", hi, 32'd0);

        // ch0 has never seen a tach edge: saturated, stall masked while off
        check("ch0_off_stall", 32'(fan_stall[0]), 32'd0);
        check("ch0_sat_uspr", 32'(fan_uspr[0 +: MB]), 32'h3FF);
        set_pct(0, 8'h40);
        repeat (1600) @(negedge clk);
        check("ch0_on_stall", 32'(fan_stall[0]), 32'd1);

        // Measurement on ch1: edges every 50 us, PPR 2 -> 100 us/rev
        repeat (5) tach_cycle(1, 50);
        check("uspr_50_50", 32'(fan_uspr[MB +: MB]), 32'd100);
        check("stall_run", 32'(fan_stall[1]), 32'd0);
        // Alternating 30/70: the first mixed revolution spans 50+30
        tach_cycle(1, 30);
        tach_cycle(1, 70);
        check("uspr_mix1", 32'(fan_uspr[MB +: MB]), 32'd80);
        tach_cycle(1, 30);
        tach_cycle(1, 70);
        check("uspr_30_70", 32'(fan_uspr[MB +: MB]), 32'd100);

        // Tach stops with duty on: saturate and stall
        repeat (4400) @(negedge clk);
        check("stall_uspr", 32'(fan_uspr[MB +: MB]), 32'h3FF);
        check("stall_set", 32'(fan_stall[1]), 32'd1);
        // Tach resumes: stall holds until a complete revolution
        repeat (2) tach_cycle(1, 50);
        check("stall_hold", 32'(fan_stall[1]), 32'd1);
        tach_cycle(1, 50);
        check("resume_uspr", 32'(fan_uspr[MB +: MB]), 32'd100);
        check("resume_stall", 32'(fan_stall[1]), 32'd0);

        // Duty 0: saturates but stall stays 0
        set_pct(1, 8'h00);
        repeat (600) @(negedge clk);
        repeat (4400) @(negedge clk);
        check("off_nostall", 32'(fan_stall[1]), 32'd0);
        check("off_uspr", 32'(fan_uspr[MB +: MB]), 32'h3FF);

        // Reset mid-kick and mid-measurement
        set_pct(1, 8'hFF);
        set_pct(0, 8'h00);
        repeat (3) tach_cycle(1, 50);
        check("pre_rst_uspr", 32'(fan_uspr[MB +: MB]), 32'd100);
        set_pct(0, 8'h20);
        wait_rise(0);
        repeat (200) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_pwm",   32'(fan_pwm),   32'd0);
        check("async_rst_uspr",  32'(fan_uspr),  32'd0);
        check("async_rst_stall", 32'(fan_stall), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) tach_cycle(1, 50);
        check("post_rst_partial", 32'(fan_uspr[MB +: MB]), 32'd0);
        tach_cycle(1, 50);
        check("post_rst_valid", 32'(fan_uspr[MB +: MB]), 32'd100);
        repeat (1400) @(negedge clk);
        count_high(0, 512, hi);
        check("post_rst_duty0", hi, 32'd64);
        count_high(1, 512, hi);
        check("post_rst_duty1", hi, 32'd512);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
